// File: rtl/mips_fetch_pkg.sv
// ---------------------------------------------------------------------------
// mips_fetch_pkg
// Shared definitions for the MIPS instruction fetch unit.
//   fetch_state_e    : FSM encoding (FETCH waits for a line, ISSUE hands out words)
//   line geometry    : 4 x 32-bit words per 128-bit line, 16-byte line alignment
//   line_base()      : line-aligned address for a given PC
// ---------------------------------------------------------------------------
package mips_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  localparam int WORDS_PER_LINE   = 4;
  localparam int WORD_BITS        = 32;
  localparam int LINE_BITS        = WORDS_PER_LINE * WORD_BITS;
  localparam int LINE_OFFSET_BITS = 4;

  function automatic logic [31:0] line_base(input logic [31:0] pc);
    return {pc[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mips_instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// mips_instruction_fetch_unit_if
// Bundles the fetch unit's memory-side, redirect and decode-side signals.
//   master : the fetch unit (drives address and the issued instruction)
//   slave  : memory / PC logic / decode stage seen as a single environment
// Signals:
//   InstructionAddress  line address to instruction memory
//   OutputInsMemory     128-bit line returned by memory (big-endian words)
//   BranchTaken/Target  single-cycle redirect strobe and its target PC
//   Instruction/InstructionPC/InstructionValid/InstructionReady
//                       valid/ready handshake towards decode
// ---------------------------------------------------------------------------
interface mips_instruction_fetch_unit_if;
  import mips_fetch_pkg::*;

  logic [31:0]          InstructionAddress;
  logic [LINE_BITS-1:0] OutputInsMemory;
  logic                 BranchTaken;
  logic [31:0]          BranchTarget;
  logic [WORD_BITS-1:0] Instruction;
  logic [31:0]          InstructionPC;
  logic                 InstructionValid;
  logic                 InstructionReady;

  modport master (
    output InstructionAddress,
    input  OutputInsMemory,
    input  BranchTaken,
    input  BranchTarget,
    output Instruction,
    output InstructionPC,
    output InstructionValid,
    input  InstructionReady
  );

  modport slave (
    input  InstructionAddress,
    output OutputInsMemory,
    output BranchTaken,
    output BranchTarget,
    input  Instruction,
    input  InstructionPC,
    input  InstructionValid,
    output InstructionReady
  );

endinterface

// File: rtl/mips_line_word_select.sv
// ---------------------------------------------------------------------------
// mips_line_word_select
// Combinational 128->32 word mux. Word 0 (byte offset 0) sits in the most
// significant 32 bits of the line.
//   line_i : 128-bit instruction line
//   sel_i  : word index, pc[3:2]
//   word_o : selected instruction word
// ---------------------------------------------------------------------------
module mips_line_word_select
  import mips_fetch_pkg::*;
(
  input  logic [LINE_BITS-1:0] line_i,
  input  logic [1:0]           sel_i,
  output logic [WORD_BITS-1:0] word_o
);

  always_comb begin
    word_o = '0;
    unique case (sel_i)
      2'd0: word_o = line_i[127:96];
      2'd1: word_o = line_i[95:64];
      2'd2: word_o = line_i[63:32];
      2'd3: word_o = line_i[31:0];
    endcase
  end

endmodule

// File: rtl/mips_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_instruction_fetch_unit
// Fetches 128-bit lines from instruction memory and issues one 32-bit
// instruction per valid/ready transfer to decode. No prefetch: a new line is
// requested only when the current one is used up or a branch redirects.
// Parameters:
//   RESET_PC     PC after reset (bits [1:0] forced to 0)
//   MEM_LATENCY  cycles from a stable address to valid line data (1..7)
// Ports:
//   ClockPulse   rising-edge clock
//   Reset        synchronous, active-high
//   bus          master side of mips_instruction_fetch_unit_if
// ---------------------------------------------------------------------------
module mips_instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1
) (
  input  logic                          ClockPulse,
  input  logic                          Reset,
  mips_instruction_fetch_unit_if.master bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  // FETCH lasts MEM_LATENCY+1 cycles: counter runs 0..MEM_LATENCY.
  localparam logic [2:0]  LAST_WAIT        = 3'(MEM_LATENCY);

  fetch_state_e         state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          pc_q, pc_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [WORD_BITS-1:0] word_sel;

  mips_line_word_select u_word_select (
    .line_i (line_q),
    .sel_i  (pc_q[3:2]),
    .word_o (word_sel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    line_d  = line_q;

    if (bus.BranchTaken) begin
      // Redirect wins over FETCH completion and sequential advance; any
      // line arriving this cycle belongs to the old stream and is dropped.
      // A concurrent transfer needs no extra action: the word was accepted.
      pc_d    = bus.BranchTarget & ~32'd3;
      state_d = FETCH;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (cnt_q == LAST_WAIT) begin
            line_d  = bus.OutputInsMemory;
            state_d = ISSUE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ISSUE: begin
          if (bus.InstructionReady) begin
            pc_d = pc_q + 32'd4;
            if (pc_q[3:2] == 2'd3) begin
              state_d = FETCH;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      pc_q    <= RESET_PC_ALIGNED;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      line_q  <= line_d;
    end
  end

  // Address follows the PC's line, so it only moves on a line crossing or
  // redirect, and stays put for the whole FETCH window.
  assign bus.InstructionAddress = line_base(pc_q);
  assign bus.InstructionValid   = (state_q == ISSUE);
  assign bus.Instruction        = (state_q == ISSUE) ? word_sel : '0;
  assign bus.InstructionPC      = (state_q == ISSUE) ? pc_q : '0;

endmodule
